// File: rtl/keyboard_move_control.sv
// keyboard_move_control: decodes PS/2 arrow/space scan codes into cursor moves and
// screen clears, sequencing the drawing datapath and guarding the screen edges.
`timescale 1ns/1ps
module keyboard_move_control #(
  parameter int          X_MAX        = 159,
  parameter int          Y_MAX        = 119,
  parameter logic [2:0]  ERASE_COLOUR = 3'b000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       key_valid,
  input  logic [7:0] key_byte,
  output logic       reset_from_controller,
  output logic       ldX,
  output logic       ldY,
  output logic       right,
  output logic       down,
  output logic       ldClr,
  output logic       control_colour_signal,
  output logic [2:0] control_colour,
  output logic       from_control,
  output logic [7:0] from_control_x,
  output logic [6:0] from_control_y,
  output logic       plot,
  output logic       busy
);
  typedef enum logic [2:0] {S_RSTDP, S_DRAW, S_IDLE, S_ERASE, S_STEP, S_CLEAR} state_t;
  localparam logic [7:0] XM = 8'(X_MAX);
  localparam logic [6:0] YM = 7'(Y_MAX);
  state_t     r_state, w_next;
  logic       r_ext, r_brk, r_axis_y, r_right, r_down;
  logic [7:0] r_px, r_cx;
  logic [6:0] r_py, r_cy;
  logic       w_code, w_up, w_down, w_left, w_right, w_clr, w_move, w_idle, w_clr_end;
  assign w_code    = key_valid && key_byte != 8'hE0 && key_byte != 8'hF0 && !r_brk;
  assign w_up      = w_code && r_ext && key_byte == 8'h75;
  assign w_down    = w_code && r_ext && key_byte == 8'h72;
  assign w_left    = w_code && r_ext && key_byte == 8'h6B;
  assign w_right   = w_code && r_ext && key_byte == 8'h74;
  assign w_clr     = w_code && !r_ext && key_byte == 8'h29;
  assign w_move    = (w_up && r_py != 7'd0) || (w_down && r_py != YM) ||
                     (w_left && r_px != 8'd0) || (w_right && r_px != XM);
  assign w_idle    = r_state == S_IDLE;
  assign w_clr_end = r_cx == XM && r_cy == YM;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) r_state <= S_RSTDP;
    else         r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RSTDP: w_next = S_DRAW;
      S_DRAW:  w_next = S_IDLE;
      S_IDLE:  w_next = w_move ? S_ERASE : w_clr ? S_CLEAR : S_IDLE;
      S_ERASE: w_next = S_STEP;
      S_STEP:  w_next = S_DRAW;
      S_CLEAR: w_next = w_clr_end ? S_RSTDP : S_CLEAR;
      default: w_next = S_RSTDP;
    endcase
  end
  // Parser, latched direction, shadow position and clear counters
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_ext    <= 1'b0;
      r_brk    <= 1'b0;
      r_axis_y <= 1'b0;
      r_right  <= 1'b0;
      r_down   <= 1'b0;
      r_px     <= '0;
      r_py     <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
    end else begin
      if (key_valid) begin
        r_ext <= key_byte == 8'hE0 || (key_byte == 8'hF0 && r_ext);
        r_brk <= key_byte == 8'hF0 || (key_byte == 8'hE0 && r_brk);
      end
      if (w_idle && w_move) begin
        r_axis_y <= w_up || w_down;
        if (w_left || w_right) r_right <= w_right;
        else                   r_down  <= w_down;
      end
      if (r_state == S_RSTDP) begin
        r_px <= '0;
        r_py <= '0;
      end else if (r_state == S_STEP) begin
        if (r_axis_y) r_py <= r_down  ? r_py + 7'd1 : r_py - 7'd1;
        else          r_px <= r_right ? r_px + 8'd1 : r_px - 8'd1;
      end
      if (w_idle && w_clr) begin
        r_cx <= '0;
        r_cy <= '0;
      end else if (r_state == S_CLEAR) begin
        r_cx <= r_cx == XM ? 8'd0 : r_cx + 8'd1;
        r_cy <= r_cx == XM ? (w_clr_end ? 7'd0 : r_cy + 7'd1) : r_cy;
      end
    end
  always_comb begin
    reset_from_controller = r_state == S_RSTDP;
    ldClr                 = r_state == S_RSTDP;
    ldX                   = r_state == S_STEP && !r_axis_y;
    ldY                   = r_state == S_STEP && r_axis_y;
    right                 = r_right;
    down                  = r_down;
    control_colour_signal = r_state == S_ERASE || r_state == S_CLEAR;
    control_colour        = control_colour_signal ? ERASE_COLOUR : 3'b000;
    from_control          = r_state == S_CLEAR;
    from_control_x        = from_control ? r_cx : 8'd0;
    from_control_y        = from_control ? r_cy : 7'd0;
    plot                  = r_state == S_DRAW || r_state == S_ERASE || r_state == S_CLEAR;
    busy                  = !w_idle;
  end
endmodule

// File: doc/keyboard_move_control.md
Name: keyboard_move_control

Overview:
- Upstream controller for the keyboard-to-VGA drawing datapath.
- Parses the PS/2 scan-code byte stream into cursor commands: arrow keys move the cursor, space clears the screen.
- Sequences the datapath's load, direction, override and reset strobes, and issues the plot strobe for the VGA adapter.
- Keeps a shadow copy of the cursor position so that moves past the screen edge are refused and never wrap.

Parameters:
- X_MAX, 159: rightmost legal x coordinate.
- Y_MAX, 119: bottom legal y coordinate.
- ERASE_COLOUR, 3'b000: colour used to erase pixels and to clear the screen.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe: key_byte holds a new scan-code byte.
- key_byte  in  8  PS/2 set-2 scan-code byte.
- reset_from_controller  out  1  synchronous reset strobe to the datapath.
- ldX  out  1  datapath x step enable.
- ldY  out  1  datapath y step enable.
- right  out  1  x step direction: 1 = +1, 0 = -1.
- down  out  1  y step direction: 1 = +1, 0 = -1.
- ldClr  out  1  datapath colour reload.
- control_colour_signal  out  1  selects control_colour instead of the datapath colour.
- control_colour  out  3  override colour.
- from_control  out  1  selects from_control_x/from_control_y instead of the datapath x/y.
- from_control_x  out  8  override x coordinate.
- from_control_y  out  7  override y coordinate.
- plot  out  1  VGA adapter write enable.
- busy  out  1  high in every state except S_IDLE.

Behaviour:
- Parser (runs every cycle, including while busy), updated only when key_valid=1:
  - byte 0xE0: set ext.
  - byte 0xF0: set brk.
  - any other byte with brk=1: release event; clear brk and ext; no command.
  - any other byte with brk=0: decode using ext, then clear ext.
- Commands:
  - ext=1: 0x75 = UP, 0x72 = DOWN, 0x6B = LEFT, 0x74 = RIGHT.
  - ext=0: 0x29 = CLEAR.
  - Every other code is ignored.
- A command is acted on only if the FSM is in S_IDLE in the cycle the byte is accepted. A command accepted while busy is dropped; there is no queue.
- Shadow position px[7:0], py[6:0]:
  - Reset to (0,0).
  - Updated on the same edge as ldX/ldY, in the same direction.
  - Set to (0,0) in S_RSTDP.
- Boundary rule: a command is refused silently (FSM stays in S_IDLE, no strobes) when it is:
  - LEFT at px=0
  - RIGHT at px=X_MAX
  - UP at py=0
  - DOWN at py=Y_MAX
- FSM states: S_RSTDP, S_DRAW, S_IDLE, S_ERASE, S_STEP, S_CLEAR. Outputs are decoded from state (Moore), except that right/down come from a registered direction latched when a move command is accepted.
  - S_RSTDP: reset_from_controller=1. Next state S_DRAW.
  - S_DRAW: plot=1, using the datapath's own x, y and colour. Next state S_IDLE.
  - S_IDLE: busy=0, all strobes 0.
    - Valid move command: go to S_ERASE.
    - CLEAR: zero the clear counters, go to S_CLEAR.
  - S_ERASE: plot=1, control_colour_signal=1, control_colour=ERASE_COLOUR. Next state S_STEP.
  - S_STEP: one-cycle ldX (LEFT/RIGHT) or ldY (UP/DOWN), with right/down set for the direction. Next state S_DRAW.
  - S_CLEAR: from_control=1, control_colour_signal=1, control_colour=ERASE_COLOUR, plot=1. from_control_x/from_control_y come from counters cx/cy:
    - cx increments every cycle.
    - At cx=X_MAX, cx wraps to 0 and cy increments.
    - At cx=X_MAX and cy=Y_MAX, go to S_RSTDP.
    - Total 160×120 = 19200 plot cycles.
- Timing:
  - Move: final byte accepted at edge T gives S_ERASE in cycle T+1, S_STEP in T+2, S_DRAW in T+3, S_IDLE in T+4.
  - Clear: S_RSTDP follows 19200 cycles after S_CLEAR is entered, then S_DRAW, then S_IDLE.
- ldClr: asserted together with reset_from_controller.
- Outside S_CLEAR: from_control=0 and from_control_x/from_control_y=0.
- Reset (resetn=0, at any time, including mid-clear or mid-move):
  - Immediately: state=S_RSTDP, ext=brk=0, px=py=0, cx=cy=0.
  - Outputs during reset: reset_from_controller=1, ldClr=1, busy=1; all other outputs 0.
  - After release: S_RSTDP → S_DRAW → S_IDLE, so the red cursor is drawn at (0,0).

Test Plan:
- Reset release -> one cycle reset_from_controller=1, then one plot with from_control=0, then busy=0 within 3 cycles.
- Bytes E0,74 from idle at (0,0) -> plot with colour 000 at (0,0); next cycle ldX=1, right=1; next cycle plot at datapath (1,0); shadow px=1.
- E0,6B at (0,0) -> no strobes, busy stays 0. DOWN pressed 119 times -> py=119; a further E0,72 -> refused.
- E0,F0,74 (release) -> no strobes; parser flags clear; a following 29 is decoded as CLEAR.
- Byte 29 -> exactly 19200 plot cycles, first at (0,0), last at (159,119), all colour 000; then reset_from_controller pulse, then draw; E0,74 sent mid-clear is dropped.
- resetn low at clear cycle 5000 -> outputs reach their reset values asynchronously; after release, a full clear does not resume and the S_RSTDP → S_DRAW sequence occurs.
